// File: rtl/counter_async_pos_rst_with_pos_en_down_load.sv
// Loadable down counter with one-shot/continuous modes, terminal-count and borrow pulses.
// Define COUNTER_DOWN_AUTO_RELOAD_EN to make a continuous-mode wrap reload the last loaded value.
module counter_async_pos_rst_with_pos_en_down_load #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             oneshot,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             tc,
    output logic             borrow,
    output logic             halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] wrap_value;
    logic             tc_next;
    logic             borrow_next;

`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reload <= '1;
        end else if (load) begin
            reload <= load_value;
        end
    end

    assign wrap_value = reload;
`else
    assign wrap_value = '1;
`endif

    // Load beats enable; HALT ignores enable until the next load.
    always_comb begin
        state_next  = state;
        out_next    = out;
        tc_next     = 1'b0;
        borrow_next = 1'b0;
        if (load) begin
            out_next   = load_value;
            state_next = RUN;
        end else if (state == RUN && enable) begin
            if (out == WIDTH'(1)) begin
                out_next = '0;
                tc_next  = 1'b1;
                if (oneshot) begin
                    state_next = HALT;
                end
            end else if (out == '0) begin
                if (oneshot) begin
                    state_next = HALT;
                end else begin
                    out_next    = wrap_value;
                    borrow_next = 1'b1;
                end
            end else begin
                out_next = out - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            out    <= '0;
            tc     <= 1'b0;
            borrow <= 1'b0;
        end else begin
            state  <= state_next;
            out    <= out_next;
            tc     <= tc_next;
            borrow <= borrow_next;
        end
    end

    assign zero   = (out == '0);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_counter_async_pos_rst_with_pos_en_down_load.sv
// Directed-vector bench for the loadable down counter; expected wrap value follows
// COUNTER_DOWN_AUTO_RELOAD_EN so the same bench covers both builds.
module tb_counter_async_pos_rst_with_pos_en_down_load;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic       oneshot;
    logic [3:0] out;
    logic       zero;
    logic       tc;
    logic       borrow;
    logic       halted;

    int checks = 0;
    int errors = 0;

    counter_async_pos_rst_with_pos_en_down_load #(.WIDTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .oneshot    (oneshot),
        .out        (out),
        .zero       (zero),
        .tc         (tc),
        .borrow     (borrow),
        .halted     (halted)
    );

    // Rising edges at 10, 20, 30 ... so the 15 ns reset release is clear of any edge.
    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_out, input logic e_tc,
                             input logic e_borrow, input logic e_halted);
        check({tag, ".out"},    16'(out),    16'(e_out));
        check({tag, ".zero"},   16'(zero),   16'(e_out == 4'd0));
        check({tag, ".tc"},     16'(tc),     16'(e_tc));
        check({tag, ".borrow"}, 16'(borrow), 16'(e_borrow));
        check({tag, ".halted"}, 16'(halted), 16'(e_halted));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
    localparam logic RELOAD_BUILD = 1'b1;
`else
    localparam logic RELOAD_BUILD = 1'b0;
`endif

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        load       = 1'b0;
        load_value = 4'd0;
        oneshot    = 1'b0;

        // 1: reset then free-running continuous count
        #14;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        tick();
        check_all("t1_wrap", 4'd15, 1'b0, 1'b1, 1'b0);
        for (int i = 14; i >= 1; i--) begin
            tick();
            check_all($sformatf("t1_cnt%0d", i), 4'(i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_all("t1_tc", 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t1_wrap2", 4'd15, 1'b0, 1'b1, 1'b0);

        // 2: one-shot halt, enable ignored in HALT, load exits
        oneshot = 1'b1; load = 1'b1; load_value = 4'd3;
        tick();
        check_all("t2_load3", 4'd3, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        check_all("t2_cnt2", 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("t2_cnt1", 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("t2_tc", 4'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) oneshot = 1'b0;
            tick();
            check_all($sformatf("t2_halt%0d", i), 4'd0, 1'b0, 1'b0, 1'b1);
        end
        load = 1'b1; load_value = 4'd7;
        tick();
        check_all("t2_load7", 4'd7, 1'b0, 1'b0, 1'b0);

        // 3: load beats enable, then hold
        enable = 1'b0; load_value = 4'd4;
        tick();
        check_all("t3_load4", 4'd4, 1'b0, 1'b0, 1'b0);
        enable = 1'b1; load_value = 4'd9;
        tick();
        check_all("t3_prio", 4'd9, 1'b0, 1'b0, 1'b0);
        load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all($sformatf("t3_hold%0d", i), 4'd9, 1'b0, 1'b0, 1'b0);
        end

        // 4: asynchronous reset pulse between edges
        load = 1'b1; load_value = 4'd6; enable = 1'b1; oneshot = 1'b0;
        tick();
        check_all("t4_load6", 4'd6, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_all("t4_inrst", 4'd0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_all("t4_postrst", 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("t4_resume", 4'd15, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("t4_resume2", 4'd14, 1'b0, 1'b0, 1'b0);

        // 5: switch to one-shot at out == 1
        load = 1'b1; load_value = 4'd2; oneshot = 1'b0;
        tick();
        check_all("t5_load2", 4'd2, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        check_all("t5_cnt1", 4'd1, 1'b0, 1'b0, 1'b0);
        oneshot = 1'b1;
        tick();
        check_all("t5_tc", 4'd0, 1'b1, 1'b0, 1'b1);

        // 6: wrap value after a load of 5, then back-to-back wraps from a load of 0
        load = 1'b1; load_value = 4'd5; oneshot = 1'b0;
        tick();
        check_all("t6_load5", 4'd5, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            tick();
            check_all($sformatf("t6_cnt%0d", i), 4'(i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check_all("t6_tc", 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("t6_wrap", RELOAD_BUILD ? 4'd5 : 4'd15, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("t6_after", RELOAD_BUILD ? 4'd4 : 4'd14, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_value = 4'd0;
        tick();
        check_all("t6_load0", 4'd0, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        check_all("t6_w0", RELOAD_BUILD ? 4'd0 : 4'd15, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("t6_w1", RELOAD_BUILD ? 4'd0 : 4'd14, 1'b0, RELOAD_BUILD, 1'b0);
        tick();
        check_all("t6_w2", RELOAD_BUILD ? 4'd0 : 4'd13, 1'b0, RELOAD_BUILD, 1'b0);
        enable = 1'b0;
        tick();
        check_all("t6_idle", RELOAD_BUILD ? 4'd0 : 4'd13, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
